if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  Instruction-fetch stage of the RV32I pipeline. It owns the PC and issues
//  word fetches to instruction memory (variable latency, one request in flight).
//  It registers each fetched instruction into the IF/ID register, which the
//  decode stage and immediate generator consume. Supports decode stall and
//  EX-stage redirect (branch/JAL/JALR) with squash of in-flight fetches.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  NOP_INS    32'h0000_0013  ifid_ins value when no valid instruction (addi x0,x0,0)
// PORTS
//  clk           in   1   clock, all state updates on posedge
//  rst           in   1   synchronous active-high reset
//  imem_req      out  1   fetch request, 1-cycle pulse, always accepted by memory
//  imem_addr     out  32  fetch byte address (= pc), bits[1:0] always 0
//  imem_rdata    in   32  returned instruction word
//  imem_rvalid   in   1   imem_rdata valid; >=1 cycle after imem_req
//  id_stall      in   1   decode cannot accept; hold IF/ID contents
//  redirect      in   1   control-flow change from EX; highest priority
//  redirect_pc   in   32  new PC; bits[1:0] cleared internally
//  ifid_valid    out  1   IF/ID register holds a live instruction
//  ifid_ins      out  32  fetched instruction
//  ifid_pc       out  32  address of ifid_ins
//  ifid_pc4      out  32  ifid_pc + 4 (mod 2^32), link value for JAL/JALR
// BEHAVIOUR
//  Reset (rst=1 at posedge): pc=RESET_PC, state=IDLE, discard=0, skid empty,
//   ifid_valid=0, ifid_ins=NOP_INS, ifid_pc=0, ifid_pc4=0. imem_req=0 while rst.
//  FSM states: IDLE (may issue), WAIT (request outstanding), HOLD (word in skid).
//  imem_req = (state==IDLE) & ~redirect & ~rst; imem_addr = pc (combinational).
//  IDLE: req issued -> WAIT. If redirect: pc<=redirect_pc&~3, stay IDLE, no req.
//  WAIT, rvalid=0: stay. If redirect: pc<=target, discard<=1, stay WAIT.
//  WAIT, rvalid=1, discard=1 or redirect: drop word, discard<=0, -> IDLE
//   (redirect also loads pc<=target).
//  WAIT, rvalid=1, slot free (ifid_valid=0 or id_stall=0): IF/ID <= {1,rdata,
//   pc,pc+4}; pc<=pc+4; -> IDLE.
//  WAIT, rvalid=1, slot busy (ifid_valid=1 & id_stall=1): skid<=rdata, -> HOLD;
//   IF/ID unchanged.
//  HOLD: when id_stall=0: IF/ID <= skid entry, pc<=pc+4, -> IDLE. Else stay.
//   Redirect in HOLD: skid dropped, pc<=target, -> IDLE.
//  IF/ID register: on redirect, ifid_valid<=0, ifid_ins<=NOP_INS (pc fields
//   don't-care). Else if id_stall=0 and no new word loaded, ifid_valid<=0 and
//   ifid_ins<=NOP_INS. id_stall with ifid_valid=0 has no effect.
//  Latency: req at cycle N, rvalid at N+k (k>=1), ifid_valid at N+k+1; next req
//   issued at N+k+1. Peak rate 1 instr / 2 cycles.
//  pc+4 wraps: 32'hFFFF_FFFC -> 32'h0000_0000. imem_rvalid outside WAIT ignored.
//  Reset mid-fetch: outstanding response arriving after reset is ignored (IDLE).
//  Never more than one outstanding request; no instruction lost or duplicated.
// TESTING
//  1 Reset then release, memory k=1 returning addr-tagged words -> req at
//    0x0,0x4,0x8 every 2 cycles; ifid_pc/ifid_ins match; ifid_pc4=ifid_pc+4.
//  2 ifid_valid=1 @pc 0x4, id_stall=1 for 5 cycles, word @0x8 arrives ->
//    HOLD, IF/ID keeps 0x4, no new req; stall drop -> IF/ID pc=0x8 next cycle.
//  3 k=3, redirect to 0x103 one cycle after req @0x10 -> word @0x10 dropped,
//    discard clears, next req addr=0x100, ifid_valid=0 until it returns.
//  4 redirect to 0x200 same cycle as rvalid -> word dropped, next cycle
//    imem_req=1 addr=0x200; no stale instruction ever seen valid.
//  5 RESET_PC=32'hFFFF_FFFC -> first ifid_pc4=0x0, second req addr=0x0.
//  6 rst asserted while WAIT with rvalid next cycle -> outputs at reset values,
//    late word ignored, first req after release addr=RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit.sv
// RV32I instruction-fetch stage: owns the PC, keeps at most one imem request in flight and
// fills the IF/ID register, parking a word in a one-entry skid while decode is stalled.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INS  = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        imem_rvalid_i,
  input  logic        id_stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        ifid_valid_o,
  output logic [31:0] ifid_ins_o,
  output logic [31:0] ifid_pc_o,
  output logic [31:0] ifid_pc4_o
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StHold = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] skid_q, skid_d;
  logic        discard_q, discard_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_ins_q, ifid_ins_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;

  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic        slot_free;
  logic        load;
  logic [31:0] load_ins;

  assign target      = redirect_pc_i & ~32'd3;
  assign pc_plus4    = pc_q + 32'd4;
  assign slot_free   = ~ifid_valid_q | ~id_stall_i;
  assign imem_req_o  = (state_q == StIdle) & ~redirect_i & ~rst_i;
  assign imem_addr_o = pc_q;

  // The PC only advances once its word has been committed to IF/ID.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    skid_d    = skid_q;
    discard_d = discard_q;
    load      = 1'b0;
    load_ins  = skid_q;
    case (state_q)
      StIdle: begin
        if (redirect_i) begin
          pc_d = target;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (imem_rvalid_i) begin
          if (discard_q || redirect_i) begin
            discard_d = 1'b0;
            state_d   = StIdle;
            if (redirect_i) begin
              pc_d = target;
            end
          end else if (slot_free) begin
            load     = 1'b1;
            load_ins = imem_rdata_i;
            pc_d     = pc_plus4;
            state_d  = StIdle;
          end else begin
            skid_d  = imem_rdata_i;
            state_d = StHold;
          end
        end else if (redirect_i) begin
          // Response still owed for the old path; swallow it when it lands.
          pc_d      = target;
          discard_d = 1'b1;
        end
      end
      StHold: begin
        if (redirect_i) begin
          pc_d    = target;
          state_d = StIdle;
        end else if (!id_stall_i) begin
          load    = 1'b1;
          pc_d    = pc_plus4;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ifid_valid_d = ifid_valid_q;
    ifid_ins_d   = ifid_ins_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    if (redirect_i) begin
      ifid_valid_d = 1'b0;
      ifid_ins_d   = NOP_INS;
    end else if (load) begin
      ifid_valid_d = 1'b1;
      ifid_ins_d   = load_ins;
      ifid_pc_d    = pc_q;
      ifid_pc4_d   = pc_plus4;
    end else if (!id_stall_i) begin
      ifid_valid_d = 1'b0;
      ifid_ins_d   = NOP_INS;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      skid_q       <= 32'd0;
      discard_q    <= 1'b0;
      ifid_valid_q <= 1'b0;
      ifid_ins_q   <= NOP_INS;
      ifid_pc_q    <= 32'd0;
      ifid_pc4_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      skid_q       <= skid_d;
      discard_q    <= discard_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_ins_q   <= ifid_ins_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
    end
  end

  assign ifid_valid_o = ifid_valid_q;
  assign ifid_ins_o   = ifid_ins_q;
  assign ifid_pc_o    = ifid_pc_q;
  assign ifid_pc4_o   = ifid_pc4_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed vector table, hand sequences for redirect/reset corners,
// and a randomized run checked against a transaction-level fetch model.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, id_stall, redirect;
  logic [31:0] redirect_pc;
  logic        rvalid, rvalid2;
  logic [31:0] rdata, rdata2;
  logic        req, req2;
  logic [31:0] addr, addr2;
  logic        ifv, ifv2;
  logic [31:0] ins, ins2, pc, pc2, pc4, pc42;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk_i(clk), .rst_i(rst), .imem_req_o(req), .imem_addr_o(addr),
    .imem_rdata_i(rdata), .imem_rvalid_i(rvalid), .id_stall_i(id_stall),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc), .ifid_valid_o(ifv),
    .ifid_ins_o(ins), .ifid_pc_o(pc), .ifid_pc4_o(pc4)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk_i(clk), .rst_i(rst), .imem_req_o(req2), .imem_addr_o(addr2),
    .imem_rdata_i(rdata2), .imem_rvalid_i(rvalid2), .id_stall_i(id_stall),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc), .ifid_valid_o(ifv2),
    .ifid_ins_o(ins2), .ifid_pc_o(pc2), .ifid_pc4_o(pc42)
  );

  typedef struct {
    logic        rst, stall, redir;
    logic [31:0] rpc;
    logic        rv;
    logic [31:0] rda;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hA5C3_0000;
  endfunction

  function automatic vec_t mk(input logic rs, input logic st, input logic rdr,
                              input logic [31:0] rpc, input logic rv, input logic [31:0] rda,
                              input logic rq, input logic [31:0] ad, input logic vl,
                              input logic [31:0] p);
    vec_t v;
    v.rst = rs; v.stall = st; v.redir = rdr; v.rpc = rpc; v.rv = rv; v.rda = rda;
    v.req = rq; v.addr = ad; v.valid = vl; v.pc = p;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; id_stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    rvalid = 1'b0; rvalid2 = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    rst = v.rst; id_stall = v.stall; redirect = v.redir; redirect_pc = v.rpc;
    rvalid = v.rv; rdata = v.rv ? word_at(v.rda) : 32'hDEAD_BEEF;
    #1;
    check1("req", req, v.req);
    check("addr", addr, v.addr);
    check1("ifid_valid", ifv, v.valid);
    check("ifid_ins", ins, v.valid ? word_at(v.pc) : NOP);
    if (v.valid) begin
      check("ifid_pc", pc, v.pc);
      check("ifid_pc4", pc4, v.pc + 32'd4);
    end
  endtask

  // Transaction-level reference state for the random run.
  logic        outst, squashed, exp_valid, exp_req, mem_busy;
  logic [31:0] exp_fetch, out_addr, exp_ins, exp_pc;
  int          mem_cnt;
  logic [31:0] pend_ins[$];
  logic [31:0] pend_pc[$];

  initial begin
    rst = 1'b1; id_stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    rvalid = 1'b0; rdata = 32'd0; rvalid2 = 1'b0; rdata2 = 32'd0;

    // Wrap-around reset PC.
    do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check1("wrap_req0", req2, 1'b1);
    check("wrap_addr0", addr2, 32'hFFFF_FFFC);
    check1("rst_valid", ifv2, 1'b0);
    check("rst_ins", ins2, NOP);
    check("rst_pc", pc2, 32'd0);
    check("rst_pc4", pc42, 32'd0);
    @(negedge clk);
    rvalid2 = 1'b1; rdata2 = word_at(32'hFFFF_FFFC);
    #1;
    check1("wrap_req_wait", req2, 1'b0);
    @(negedge clk);
    rvalid2 = 1'b0;
    #1;
    check1("wrap_valid", ifv2, 1'b1);
    check("wrap_pc", pc2, 32'hFFFF_FFFC);
    check("wrap_pc4", pc42, 32'h0000_0000);
    check("wrap_ins", ins2, word_at(32'hFFFF_FFFC));
    check1("wrap_req1", req2, 1'b1);
    check("wrap_addr1", addr2, 32'h0000_0000);

    // Streaming at k=1, reset from a busy state, then a 5-cycle stall into the skid.
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,     1, 32'h0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h0, 0, 32'h0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,     1, 32'h4, 1, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h4, 0, 32'h4, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,     1, 32'h8, 1, 32'h4));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h8, 0, 32'h8, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,     1, 32'hC, 1, 32'h8));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,     0, 32'hC, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,     0, 32'h0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,     1, 32'h0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h0, 0, 32'h0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,     1, 32'h4, 1, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h4, 0, 32'h4, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0,     1, 32'h8, 1, 32'h4));
    tbl.push_back(mk(0, 1, 0, 0, 1, 32'h8, 0, 32'h8, 1, 32'h4));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0,     0, 32'h8, 1, 32'h4));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0,     0, 32'h8, 1, 32'h4));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0,     0, 32'h8, 1, 32'h4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,     0, 32'h8, 1, 32'h4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,     1, 32'hC, 1, 32'h8));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,     0, 32'hC, 0, 0));
    do_reset();
    foreach (tbl[i]) apply(tbl[i]);

    // Redirect while a k=3 fetch is outstanding; target low bits must be cleared.
    do_reset();
    apply(mk(0, 0, 1, 32'h10,  0, 0,       0, 32'h0,   0, 0));
    apply(mk(0, 0, 0, 0,       0, 0,       1, 32'h10,  0, 0));
    apply(mk(0, 0, 1, 32'h103, 0, 0,       0, 32'h10,  0, 0));
    apply(mk(0, 0, 0, 0,       0, 0,       0, 32'h100, 0, 0));
    apply(mk(0, 0, 0, 0,       1, 32'h10,  0, 32'h100, 0, 0));
    apply(mk(0, 0, 0, 0,       0, 0,       1, 32'h100, 0, 0));
    apply(mk(0, 0, 0, 0,       1, 32'h100, 0, 32'h100, 0, 0));
    apply(mk(0, 0, 0, 0,       0, 0,       1, 32'h104, 1, 32'h100));
    // Redirect coinciding with the response.
    apply(mk(0, 0, 1, 32'h200, 1, 32'h104, 0, 32'h104, 0, 0));
    apply(mk(0, 0, 0, 0,       0, 0,       1, 32'h200, 0, 0));
    apply(mk(0, 0, 0, 0,       1, 32'h200, 0, 32'h200, 0, 0));
    apply(mk(0, 0, 0, 0,       0, 0,       1, 32'h204, 1, 32'h200));
    // Reset while waiting; the late response must be ignored.
    apply(mk(1, 0, 0, 0,       0, 0,       0, 32'h204, 0, 0));
    apply(mk(0, 0, 0, 0,       1, 32'h204, 1, 32'h0,   0, 0));
    check("late_rst_pc", pc, 32'd0);
    check("late_rst_pc4", pc4, 32'd0);
    apply(mk(0, 0, 0, 0,       0, 0,       0, 32'h0,   0, 0));
    apply(mk(0, 0, 0, 0,       1, 32'h0,   0, 32'h0,   0, 0));
    apply(mk(0, 0, 0, 0,       0, 0,       1, 32'h4,   1, 32'h0));

    // Randomized run against the fetch model.
    do_reset();
    outst = 1'b0; squashed = 1'b0; exp_valid = 1'b0; mem_busy = 1'b0; mem_cnt = 0;
    exp_fetch = 32'd0; out_addr = 32'd0; exp_ins = NOP; exp_pc = 32'd0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = 1'b0;
      id_stall = ($urandom_range(0, 2) == 0);
      redirect = ($urandom_range(0, 11) == 0);
      redirect_pc = $urandom;
      rvalid = 1'b0;
      rdata = $urandom;
      if (mem_busy) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          rvalid = 1'b1;
          rdata = word_at(out_addr);
          mem_busy = 1'b0;
        end
      end else if ($urandom_range(0, 15) == 0) begin
        rvalid = 1'b1;
      end
      #1;
      check1("rnd_valid", ifv, exp_valid);
      if (exp_valid) begin
        check("rnd_ins", ins, exp_ins);
        check("rnd_pc", pc, exp_pc);
        check("rnd_pc4", pc4, exp_pc + 32'd4);
      end else begin
        check("rnd_nop", ins, NOP);
      end
      exp_req = !outst && (pend_ins.size() == 0) && !redirect;
      check1("rnd_req", req, exp_req);
      if (req) check("rnd_addr", addr, exp_fetch);

      if (rvalid && outst) begin
        outst = 1'b0;
        if (!squashed && !redirect) begin
          pend_ins.push_back(rdata);
          pend_pc.push_back(out_addr);
          exp_fetch = out_addr + 32'd4;
        end
      end
      if (redirect) begin
        pend_ins.delete();
        pend_pc.delete();
        if (outst) squashed = 1'b1;
        exp_fetch = {redirect_pc[31:2], 2'b00};
        exp_valid = 1'b0;
      end else if ((pend_ins.size() != 0) && (!exp_valid || !id_stall)) begin
        exp_valid = 1'b1;
        exp_ins = pend_ins.pop_front();
        exp_pc = pend_pc.pop_front();
      end else if (!id_stall) begin
        exp_valid = 1'b0;
      end
      if (exp_req) begin
        outst = 1'b1;
        squashed = 1'b0;
        out_addr = exp_fetch;
        mem_busy = 1'b1;
        mem_cnt = $urandom_range(1, 3);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
